// File: rtl/rv_muldiv_pkg.sv
// Shared types and opcode helpers for the iterative RV32M multiply/divide unit.
package rv_muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CALC  = 2'd1,
      ST_FIXUP = 2'd2,
      ST_DONE  = 2'd3
   } muldiv_state_e;

   function automatic logic is_div(input muldiv_op_e op);
      return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

   function automatic logic is_signed_a(input muldiv_op_e op);
      return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction

   function automatic logic is_signed_b(input muldiv_op_e op);
      return op inside {OP_MULH, OP_DIV, OP_REM};
   endfunction

endpackage

// File: rtl/rv_muldiv_if.sv
// Request/response handshake bundle between the execute stage and the muldiv unit.
interface rv_muldiv_if #(
   parameter int unsigned XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      funct3;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;

   modport master (
      output in_valid, funct3, a, b, out_ready,
      input  in_ready, out_valid, result
   );

   modport slave (
      input  in_valid, funct3, a, b, out_ready,
      output in_ready, out_valid, result
   );
endinterface

// File: rtl/muldiv_sign_fix.sv
// Combinational final stage: applies result signs and picks product half / quotient / remainder.
module muldiv_sign_fix
   import rv_muldiv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  muldiv_op_e        op_i,
   input  logic [2*XLEN-1:0] acc_i,
   input  logic              neg_i,
   input  logic              a_neg_i,
   input  logic              b_zero_i,
   output logic [XLEN-1:0]   result_c_o
);
   localparam int unsigned W2 = 2 * XLEN;

   logic [W2-1:0]   prod_fix;
   logic [XLEN-1:0] quo_fix;
   logic [XLEN-1:0] rem_fix;

   always_comb begin
      prod_fix   = neg_i ? W2'(0) - acc_i : acc_i;
      // divide-by-zero quotient must stay all ones regardless of operand signs
      quo_fix    = (neg_i && !b_zero_i) ? XLEN'(0) - acc_i[XLEN-1:0] : acc_i[XLEN-1:0];
      rem_fix    = a_neg_i ? XLEN'(0) - acc_i[W2-1:XLEN] : acc_i[W2-1:XLEN];
      result_c_o = prod_fix[XLEN-1:0];
      unique case (op_i)
         OP_MUL:                       result_c_o = prod_fix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: result_c_o = prod_fix[W2-1:XLEN];
         OP_DIV, OP_DIVU:              result_c_o = quo_fix;
         OP_REM, OP_REMU:              result_c_o = rem_fix;
         default:                      result_c_o = prod_fix[XLEN-1:0];
      endcase
   end
endmodule

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit, one bit per cycle, valid/ready on both sides.
// MULDIV_EARLY_OUT_EN: trivial ops (zero operands, divide-by-zero, DIV overflow) skip the iteration.
module rv_muldiv_unit
   import rv_muldiv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input logic         clk,
   input logic         reset,
   input logic         kill,
   rv_muldiv_if.slave  bus
);
   localparam int unsigned CNT_W = $clog2(XLEN + 1);
   localparam int unsigned W2    = 2 * XLEN;

   muldiv_state_e   state_q;
   muldiv_op_e      op_q;
   logic [CNT_W-1:0] cnt_q;
   logic [XLEN-1:0] opnd_q;
   logic [XLEN-1:0] result_q;
   logic [W2-1:0]   acc_q;
   logic            neg_q;
   logic            a_neg_q;
   logic            b_zero_q;
   logic            out_valid_q;
   logic            in_ready_q;

   muldiv_op_e      op_in;
   logic            a_neg_in;
   logic            b_neg_in;
   logic [XLEN-1:0] a_abs;
   logic [XLEN-1:0] b_abs;
   logic [XLEN-1:0] opnd_in;
   logic [W2-1:0]   acc_in;

   // Operand magnitudes; acc holds the multiplier (MUL*) or dividend (DIV*) in its low half
   always_comb begin
      op_in    = muldiv_op_e'(bus.funct3);
      a_neg_in = is_signed_a(op_in) & bus.a[XLEN-1];
      b_neg_in = is_signed_b(op_in) & bus.b[XLEN-1];
      a_abs    = a_neg_in ? XLEN'(0) - bus.a : bus.a;
      b_abs    = b_neg_in ? XLEN'(0) - bus.b : bus.b;
      if (is_div(op_in)) begin
         opnd_in = b_abs;
         acc_in  = {{XLEN{1'b0}}, a_abs};
      end else begin
         opnd_in = a_abs;
         acc_in  = {{XLEN{1'b0}}, b_abs};
      end
   end

   logic [XLEN:0] mul_sum;
   logic [XLEN:0] div_sh;
   logic [XLEN:0] div_diff;
   logic [W2-1:0] acc_step;

   // One iteration: shift-add for multiply, restoring subtract for divide
   always_comb begin
      mul_sum  = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : (XLEN+1)'(0));
      div_sh   = acc_q[W2-1:XLEN-1];
      div_diff = div_sh - {1'b0, opnd_q};
      if (!is_div(op_q))
         acc_step = {mul_sum, acc_q[XLEN-1:1]};
      else if (div_diff[XLEN])
         acc_step = {acc_q[W2-2:0], 1'b0};
      else
         acc_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
   end

   logic [XLEN-1:0] fix_result;

   muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
      .op_i       (op_q),
      .acc_i      (acc_q),
      .neg_i      (neg_q),
      .a_neg_i    (a_neg_q),
      .b_zero_i   (b_zero_q),
      .result_c_o (fix_result)
   );

`ifdef MULDIV_EARLY_OUT_EN
   logic            early_c;
   logic [XLEN-1:0] early_res;

   always_comb begin
      early_c   = 1'b0;
      early_res = '0;
      if (is_div(op_in)) begin
         if (bus.b == '0) begin
            early_c   = 1'b1;
            early_res = (op_in inside {OP_DIV, OP_DIVU}) ? '1 : bus.a;
         end else if ((op_in inside {OP_DIV, OP_REM}) &&
                      (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.b)) begin
            early_c   = 1'b1;
            early_res = (op_in == OP_DIV) ? bus.a : '0;
         end
      end else if ((bus.a == '0) || (bus.b == '0)) begin
         early_c = 1'b1;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_MUL;
         cnt_q       <= '0;
         opnd_q      <= '0;
         acc_q       <= '0;
         neg_q       <= 1'b0;
         a_neg_q     <= 1'b0;
         b_zero_q    <= 1'b0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else if (kill) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  op_q       <= op_in;
                  opnd_q     <= opnd_in;
                  acc_q      <= acc_in;
                  neg_q      <= a_neg_in ^ b_neg_in;
                  a_neg_q    <= a_neg_in;
                  b_zero_q   <= (bus.b == '0);
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
                  if (early_c) begin
                     result_q <= early_res;
                     state_q  <= ST_DONE;
                  end else begin
                     state_q  <= ST_CALC;
                  end
`else
                  state_q    <= ST_CALC;
`endif
               end
            end
            ST_CALC: begin
               acc_q <= acc_step;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(XLEN - 1))
                  state_q <= ST_FIXUP;
            end
            ST_FIXUP: begin
               result_q <= fix_result;
               state_q  <= ST_DONE;
            end
            ST_DONE: begin
               // result settles one edge before out_valid is raised
               if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
               end else if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Self-checking bench for rv_muldiv_unit: directed RV32M corner cases plus random ops vs. an arithmetic model.
module tb_rv_muldiv_unit;
   localparam int unsigned XLEN = 32;
   localparam logic [31:0] MIN_INT = 32'h8000_0000;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic kill = 1'b0;

   always #5 clk = ~clk;

   rv_muldiv_if #(.XLEN(XLEN)) bus ();

   rv_muldiv_unit #(.XLEN(XLEN)) dut (
      .clk   (clk),
      .reset (reset),
      .kill  (kill),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference results straight from the RISC-V M-extension definitions
   function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint          sa;
      longint          sb;
      longint          ub;
      longint unsigned ua_u;
      longint unsigned ub_u;
      logic [63:0]     t;
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      ub   = longint'({32'b0, b});
      ua_u = {32'b0, a};
      ub_u = {32'b0, b};
      case (f)
         3'd0: begin t = sa * sb;     return t[31:0];  end
         3'd1: begin t = sa * sb;     return t[63:32]; end
         3'd2: begin t = sa * ub;     return t[63:32]; end
         3'd3: begin t = ua_u * ub_u; return t[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == MIN_INT && b == 32'hFFFF_FFFF) return a;
            t = sa / sb; return t[31:0];
         end
         3'd5: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 32'd0) return a;
            if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'd0;
            t = sa % sb; return t[31:0];
         end
         default: begin
            if (b == 32'd0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
      if (f[2] && b == 32'd0) return 1;
      if ((f == 3'd4 || f == 3'd6) && a == MIN_INT && b == 32'hFFFF_FFFF) return 1;
      if (!f[2] && (a == 32'd0 || b == 32'd0)) return 1;
`endif
      return XLEN + 2;
   endfunction

   function automatic logic [31:0] rnd_opnd();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return MIN_INT;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      int g;
      @(negedge clk);
      bus.funct3   = f;
      bus.a        = a;
      bus.b        = b;
      bus.in_valid = 1'b1;
      g = 0;
      while (!bus.in_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (!bus.in_ready) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic wait_result(output logic [31:0] res, output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      res = bus.result;
   endtask

   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] res;
      int          lat;
      start_op(f, a, b);
      wait_result(res, lat);
      chk({tag, "_res"}, res, ref_res(f, a, b));
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat(f, a, b)));
      @(posedge clk);
      #1 chk({tag, "_retire"}, 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] res;
      logic [31:0] held;
      int          lat;
      logic        seen;

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.funct3    = 3'd0;
      bus.a         = '0;
      bus.b         = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_result", bus.result, 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk) reset = 1'b1;

      run_op("mul_neg",     3'd0, 32'd7, 32'hFFFF_FFFD);
      run_op("mulh_min",    3'd1, MIN_INT, MIN_INT);
      run_op("mulhu_max",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("mulhsu_max",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("div_neg",     3'd4, 32'hFFFF_FFF9, 32'd2);
      run_op("rem_neg",     3'd6, 32'hFFFF_FFF9, 32'd2);
      run_op("divu",        3'd5, 32'd100, 32'd7);
      run_op("remu",        3'd7, 32'd100, 32'd7);
      run_op("divu_zero",   3'd5, 32'h1234, 32'd0);
      run_op("rem_zero",    3'd6, 32'h1234, 32'd0);
      run_op("div_ovf",     3'd4, MIN_INT, 32'hFFFF_FFFF);
      run_op("rem_ovf",     3'd6, MIN_INT, 32'hFFFF_FFFF);
      run_op("mul_zero",    3'd0, 32'd0, 32'h1234_5678);

      for (int i = 0; i < 40; i++) begin
         run_op($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd());
      end

      // Consumer stall: result and handshake must hold, new requests ignored
      @(negedge clk) bus.out_ready = 1'b0;
      start_op(3'd0, 32'd7, 32'd9);
      wait_result(held, lat);
      chk("stall_first", held, 32'd63);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.funct3   = 3'd5;
         bus.a        = $urandom;
         bus.b        = 32'd3;
         @(posedge clk);
         #1;
         chk("stall_valid", 32'(bus.out_valid), 32'd1);
         chk("stall_result", bus.result, 32'd63);
         chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 chk("stall_retire", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1 chk("stall_no_accept", 32'(bus.in_ready), 32'd1);

      // Kill in the 10th CALC cycle
      start_op(3'd0, 32'h1234, 32'h5678);
      repeat (9) @(posedge clk);
      @(negedge clk) kill = 1'b1;
      @(posedge clk);
      #1 kill = 1'b0;
      chk("kill_in_ready", 32'(bus.in_ready), 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1 if (bus.out_valid) seen = 1'b1;
      end
      chk("kill_no_valid", 32'(seen), 32'd0);
      chk("kill_result_kept", bus.result, 32'd63);

      // Reset mid-CALC clears result and drops the op
      start_op(3'd4, 32'd1000, 32'd7);
      repeat (14) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_result", bus.result, 32'd0);
      chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk) reset = 1'b1;
      start_op(3'd0, 32'd3, 32'd5);
      wait_result(res, lat);
      chk("post_rst_mul", res, 32'd15);
      chk("post_rst_lat", 32'(lat), 32'(XLEN + 2));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
